// File: rtl/dac_pwm.sv
// dac_pwm: turns WIDTH-bit samples into a 1-bit PWM stream of period 2^WIDTH.
// Samples come in over a start/ready handshake into a one-entry pending
// buffer and only take effect at a period boundary.
module dac_pwm #(
    parameter int WIDTH = 8,
    parameter bit HOLD  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] digital_input,
    output logic             sample_ready,
    output logic             analog_output,
    output logic             period_done,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] active_q;
    logic [WIDTH-1:0] pend_q;
    logic             pend_vld_q;
    logic             out_q;
    logic             busy_q;
    logic             overrun_q;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] duty_nxt;

    // Handshake, period-end decode and the duty that applies to the next position.
    always_comb begin
        sample_ready = (state_q == IDLE) || !pend_vld_q;
        accept       = start && sample_ready;
        last         = (state_q == RUN) && (cnt_q == CNT_MAX);
        cnt_inc      = cnt_q + 1'b1;
        duty_nxt     = active_q;
        if (last) begin
            // Pending wins; otherwise a sample accepted on the boundary edge
            // goes straight into active without passing through pending.
            if (pend_vld_q)  duty_nxt = pend_q;
            else if (accept) duty_nxt = digital_input;
        end
    end

    // Control FSM, period counter, sample buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            active_q   <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            out_q      <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (start && !sample_ready) overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    out_q <= 1'b0;
                    if (accept) begin
                        active_q <= digital_input;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        out_q    <= (digital_input != '0);
                    end
                end
                RUN: begin
                    cnt_q <= cnt_inc;
                    out_q <= (cnt_inc < duty_nxt);
                    if (last) begin
                        if (pend_vld_q) begin
                            active_q   <= pend_q;
                            pend_vld_q <= 1'b0;
                        end else if (accept) begin
                            active_q <= digital_input;
                        end else if (!HOLD) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            out_q   <= 1'b0;
                            cnt_q   <= '0;
                        end
                    end else if (accept) begin
                        pend_q     <= digital_input;
                        pend_vld_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign analog_output = out_q;
    assign period_done   = last;
    assign busy          = busy_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_dac_pwm.sv
// Directed bench for dac_pwm: one HOLD=1 and one HOLD=0 instance, WIDTH=8.
module tb_dac_pwm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0, start0 = 1'b0;
    logic [7:0] din1 = '0, din0 = '0;
    logic       rdy1, out1, pd1, busy1, ovr1;
    logic       rdy0, out0, pd0, busy0, ovr0;

    int nvec  = 0;
    int nfail = 0;
    logic rdy_log [256];

    always #5 clk = ~clk;

    dac_pwm #(.WIDTH(8), .HOLD(1'b1)) u_hold (
        .clk(clk), .rst(rst), .start(start1), .digital_input(din1),
        .sample_ready(rdy1), .analog_output(out1), .period_done(pd1),
        .busy(busy1), .overrun(ovr1)
    );

    dac_pwm #(.WIDTH(8), .HOLD(1'b0)) u_once (
        .clk(clk), .rst(rst), .start(start0), .digital_input(din0),
        .sample_ready(rdy0), .analog_output(out0), .period_done(pd0),
        .busy(busy0), .overrun(ovr0)
    );

    typedef struct {
        logic [7:0] duty;
        int         exp_high;
    } vec_t;

    vec_t vt [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic accept1(input logic [7:0] d);
        start1 = 1'b1;
        din1   = d;
        tick();
        start1 = 1'b0;
    endtask

    // Walks one full period of the HOLD=1 instance starting at position 0,
    // optionally raising start at two positions.
    task automatic period(input int duty, input int ip1, input logic [7:0] id1,
                          input int ip2, input logic [7:0] id2,
                          output int highs, output int bad, output int pdpos);
        highs = 0;
        bad   = 0;
        pdpos = -1;
        for (int p = 0; p < 256; p++) begin
            rdy_log[p] = rdy1;
            if (out1) highs++;
            if (out1 != (p < duty)) bad++;
            if (pd1 && pdpos < 0) pdpos = p;
            if (p == ip1) begin start1 = 1'b1; din1 = id1; end
            if (p == ip2) begin start1 = 1'b1; din1 = id2; end
            tick();
            start1 = 1'b0;
        end
    endtask

    initial begin
        int h, b, pd;

        vt[0] = '{8'h00, 0};
        vt[1] = '{8'h01, 1};
        vt[2] = '{8'h40, 64};
        vt[3] = '{8'h80, 128};
        vt[4] = '{8'hFE, 254};
        vt[5] = '{8'hFF, 255};

        // reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_out", out1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_ready", rdy1, 1);
        chk("rst_overrun", ovr1, 0);
        chk("rst_pdone", pd1, 0);

        // table: one full period per duty value
        foreach (vt[i]) begin
            rst = 1'b1; tick(); rst = 1'b0;
            accept1(vt[i].duty);
            chk($sformatf("v%0d_busy", i), busy1, 1);
            period(vt[i].duty, -1, 8'h00, -1, 8'h00, h, b, pd);
            chk($sformatf("v%0d_highs", i), h, vt[i].exp_high);
            chk($sformatf("v%0d_pattern", i), b, 0);
            chk($sformatf("v%0d_pdone_pos", i), pd, 255);
        end

        // mid-period update: 0x20 running, 0xC0 arrives at position 100
        rst = 1'b1; tick(); rst = 1'b0;
        accept1(8'h20);
        period(32, 100, 8'hC0, -1, 8'h00, h, b, pd);
        chk("mid_p1_highs", h, 32);
        chk("mid_p1_pattern", b, 0);
        chk("mid_rdy_before", rdy_log[100], 1);
        chk("mid_rdy_after", rdy_log[101], 0);
        chk("mid_rdy_last", rdy_log[255], 0);
        chk("mid_overrun_clear", ovr1, 0);

        // period 2 uses 0xC0; fill pending with 0x60 then overrun with 0x11
        period(192, 50, 8'h60, 60, 8'h11, h, b, pd);
        chk("mid_p2_highs", h, 192);
        chk("mid_p2_pattern", b, 0);
        chk("mid_p2_rdy_pos0", rdy_log[0], 1);
        chk("ovr_rdy_full", rdy_log[51], 0);
        chk("ovr_set", ovr1, 1);

        // period 3 takes 0x60 (the dropped 0x11 never shows); bypass 0x10 at the boundary
        period(96, 255, 8'h10, -1, 8'h00, h, b, pd);
        chk("ovr_p3_highs", h, 96);
        chk("ovr_p3_pattern", b, 0);
        chk("byp_rdy_at_end", rdy_log[255], 1);
        period(16, -1, 8'h00, -1, 8'h00, h, b, pd);
        chk("byp_p4_highs", h, 16);
        chk("byp_p4_pattern", b, 0);
        period(16, -1, 8'h00, -1, 8'h00, h, b, pd);
        chk("hold_p5_highs", h, 16);
        chk("hold_p5_pdone", pd, 255);
        chk("ovr_sticky", ovr1, 1);

        // reset in the middle of a 0xF0 period at position 10
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_ovr_clear", ovr1, 0);
        accept1(8'hF0);
        for (int p = 0; p < 10; p++) tick();
        chk("rstmid_out_pre", out1, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rstmid_out", out1, 0);
        chk("rstmid_busy", busy1, 0);
        chk("rstmid_ready", rdy1, 1);
        chk("rstmid_overrun", ovr1, 0);
        accept1(8'h40);
        period(64, -1, 8'h00, -1, 8'h00, h, b, pd);
        chk("rstmid_restart_highs", h, 64);
        chk("rstmid_restart_pattern", b, 0);
        chk("rstmid_restart_pdone", pd, 255);

        // HOLD=0: one period of 0x80, then back to idle
        rst = 1'b1; tick(); rst = 1'b0;
        start0 = 1'b1; din0 = 8'h80; tick(); start0 = 1'b0;
        chk("once_busy", busy0, 1);
        h = 0; b = 0; pd = -1;
        for (int p = 0; p < 256; p++) begin
            if (out0) h++;
            if (out0 != (p < 128)) b++;
            if (pd0 && pd < 0) pd = p;
            tick();
        end
        chk("once_highs", h, 128);
        chk("once_pattern", b, 0);
        chk("once_pdone", pd, 255);
        chk("once_idle_busy", busy0, 0);
        chk("once_idle_out", out0, 0);
        chk("once_idle_ready", rdy0, 1);
        h = 0;
        for (int p = 0; p < 20; p++) begin
            if (out0 || pd0 || busy0) h++;
            tick();
        end
        chk("once_stays_idle", h, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/dac_pwm.md
Name: dac_pwm

Overview:
- Digital-to-analog counterpart of the ADC capture path: turns WIDTH-bit digital samples into a 1-bit pulse-width-modulated stream for an external RC low-pass filter.
- Sits at the analog output pad.
- Samples arrive through a start/ready handshake and are double-buffered, so a new sample takes effect only on a PWM period boundary.

Parameters:
- WIDTH, 8, sample width; PWM period is 2^WIDTH clock cycles.
- HOLD, 1, 1 = keep repeating the last sample when no new one is pending; 0 = return to IDLE after the period ends.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  sample valid; the sample is accepted on any edge where start && sample_ready.
- digital_input  input  WIDTH  sample (duty value).
- sample_ready  output  1  high when a sample can be accepted.
- analog_output  output  1  registered PWM stream.
- period_done  output  1  one-cycle pulse in the last cycle of each period.
- busy  output  1  high in RUN.
- overrun  output  1  sticky; set when start arrives while sample_ready=0; cleared only by rst.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state=IDLE, cnt=0, active=0, pending empty, analog_output=0, period_done=0, busy=0, overrun=0, sample_ready=1.
  - Takes priority over every other event, including mid-period; the output drops to 0 on that edge.
- States: IDLE, RUN.
- IDLE:
  - analog_output=0, sample_ready=1.
  - On accept: active<=digital_input, cnt<=0, state<=RUN, analog_output<=(0<digital_input).
- RUN, period position p=cnt (0..2^WIDTH-1):
  - Each edge: cnt<=cnt+1 (wraps to 0 after max).
  - analog_output<=((cnt+1) mod 2^WIDTH < duty), where duty is the value active holds in the next period position.
  - Net effect: analog_output is high for exactly duty of each 2^WIDTH cycles, at positions 0..duty-1.
  - Duty arithmetic: unsigned WIDTH-bit compare. duty=0 gives a constant low. duty=2^WIDTH-1 gives high for all but the last position; 100% is not reachable.
- Pending buffer (one entry):
  - sample_ready=1 in RUN iff pending is empty.
  - An accept in RUN writes pending.
- Period end (cycle with cnt=2^WIDTH-1):
  - period_done=1 for that cycle only.
  - At the edge closing the period:
    - If pending is full: active<=pending, pending is emptied, the next period uses the new duty.
    - If pending is empty and start && sample_ready on this same edge: digital_input bypasses directly into active.
    - Otherwise, if HOLD=1: active is unchanged and the next period starts.
    - Otherwise (HOLD=0): state<=IDLE, analog_output<=0, cnt<=0.
- Simultaneous accept and period end with pending full: sample_ready=0, so start is ignored and overrun is set.
- start while sample_ready=0: the sample is dropped and overrun<=1; active and pending are untouched.
- busy = (state==RUN), registered.
- Latency: the first PWM cycle is the cycle immediately after the accept edge.
- A pending sample appears at most 2^WIDTH cycles after its accept.

Test Plan:
- rst, then start with digital_input=8'h40 (WIDTH=8) → busy=1; analog_output high for exactly 64 of the next 256 cycles (positions 0..63); period_done pulses at position 255.
- Duty extremes: 8'h00 → output low for a full period. 8'hFF → high for 255 cycles, low at position 255.
- Mid-period update: load 8'h20; at position 100 start with 8'hC0 → the rest of the current period still uses 32; the next period is high for 192 cycles; sample_ready=0 from the accept until the boundary edge.
- Overrun: pending full, then start with 8'h11 → overrun=1, pending value unchanged, sample dropped. Further periods follow the pending value. overrun stays 1 until rst.
- HOLD=0 with a single sample 8'h80 → exactly one period of 128 high cycles, then IDLE with busy=0 and analog_output=0. HOLD=1 → period repeats indefinitely.
- Reset mid-period: rst asserted at position 10 with duty 8'hF0 → next cycle analog_output=0, busy=0, sample_ready=1, overrun=0; a subsequent start restarts cleanly at position 0.
